fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the MIPS instruction-fetch path: owns the program counter, drives the synchronous instruction RAM, and shares that RAM between the fetch stream and a program loader. It sits between the decode/execute control and the instruction RAM. It replaces the free-running combinational address update with a registered, stall-aware, redirect-aware sequencer that emits a valid-qualified instruction stream.

## Interface
- ADDR_W, 4, instruction RAM address width (word-addressed)
- DATA_W, 32, instruction width
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- run  in  1  level; enable fetching
- stall  in  1  level; hold fetch stream (downstream busy)
- jump_en / jump_addr  in  1 / ADDR_W  redirect from decode
- branch_en / branch_addr  in  1 / ADDR_W  redirect from execute
- load_req  in  1  loader requests one RAM write
- load_addr / load_data  in  ADDR_W / DATA_W  loader write address/data
- load_ack  out  1  one-cycle pulse, write performed this cycle
- ram_addr  out  ADDR_W  RAM address
- ram_we / ram_re  out  1 / 1  RAM write/read strobes (enable tied high at RAM)
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after ram_re
- instr  out  DATA_W  fetched instruction
- pc_out / pc_plus1  out  ADDR_W / ADDR_W  address of instr and address+1
- instr_valid  out  1  instr/pc_out qualify

## Operation
- States: IDLE, LOAD, FETCH. Reset -> IDLE, PC=0.
- IDLE: ram_re=0, ram_we=0, instr_valid=0. load_req=1 -> LOAD (load wins over run). Else run=1 -> FETCH. PC held.
- LOAD (1 cycle): ram_we=1, ram_addr/ram_din = load_addr/load_data captured in IDLE, load_ack=1; -> IDLE. Loader drops load_req the cycle after ack or a further write occurs. load_req ignored in FETCH (load_ack stays 0).
- FETCH, each cycle: ram_re=1, ram_addr=PC. Next PC by priority: branch_en -> branch_addr; jump_en -> jump_addr; stall -> PC; else PC+1.
- Redirect (branch_en or jump_en) squashes the in-flight read: instr_valid=0 next cycle. Redirect is taken even under stall.
- Both redirects in one cycle: branch wins (older instruction).
- PC+1 wraps modulo 2^ADDR_W (4'hF -> 4'h0, no flag). pc_plus1 wraps the same way.
- run=0 in FETCH -> IDLE next cycle; in-flight read discarded (instr_valid=0); PC keeps the next unissued address, so run=1 resumes there.
- instr: ram_dout when the previous cycle issued a read and was not stalled. Otherwise the held copy.

## Timing
- Fetch latency 1: address issued in cycle k -> instr/pc_out/instr_valid=1 in cycle k+1.
- First fetch: run sampled high in IDLE at cycle n -> ram_re=1, ram_addr=PC at n+1 -> instr_valid at n+2.
- Stall at cycle k: PC, ram_addr, instr, pc_out, pc_plus1, instr_valid all held through k+1 and each stalled cycle. Release resumes with no lost or duplicated instruction.
- Redirect at cycle k: ram_addr=target at k+1, instr_valid=0 at k+1, target instr valid at k+2.
- Throughput: one instruction per cycle when unstalled and unredirected.
- Reset values: state IDLE, PC=0, ram_addr=0, ram_we=0, ram_re=0, ram_din=0, load_ack=0, instr=0, pc_out=0, pc_plus1=0, instr_valid=0.
- Reset mid-LOAD: write aborted, ram_we=0 the next cycle. Reset mid-FETCH: squash, PC=0.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count[15:0] and redirect_count[15:0].
  - fetch_count increments per cycle with instr_valid=1 and stall=0.
  - redirect_count increments per taken redirect.
  - Both saturate at 16'hFFFF and clear on reset.
- FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Load then run: write 0xA0+i to addresses 0..3 via load_req (four load_ack pulses), then run=1 -> instr 0xA0,0xA1,0xA2,0xA3 with pc_out 0..3 on consecutive cycles, first valid two cycles after run.
- Wrap: PC at 4'hE, run free -> pc_out E, F, 0, 1; pc_plus1 F, 0, 1, 2.
- Stall: assert stall 3 cycles while pc_out=2 -> instr/pc_out held at 2 with instr_valid=1; release -> pc_out 3 next cycle, no duplicate.
- Redirect priority: jump_en (addr 5) and branch_en (addr 9) same cycle at PC=3 -> instr_valid=0 next cycle, then pc_out=9, 10.
- Load during FETCH: load_req=1 while fetching -> load_ack stays 0, ram_we stays 0. Drop run -> IDLE, then write occurs with ack.
- Reset mid-LOAD: reset in LOAD cycle -> ram_we=0 next cycle, all outputs at reset values. With FETCH_PERF_EN: counts return to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a synchronous instruction RAM and
// arbitrates it with a program loader. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              stall_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ack_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic [ADDR_W-1:0] pc_plus1_o,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_count_o,
  output logic [15:0]       redirect_count_o,
`endif
  output logic              instr_valid_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StFetch} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] pc_plus1_q, pc_plus1_d;
  logic              valid_q, valid_d;
  logic              take_q, take_d;
  logic [DATA_W-1:0] hold_q;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  // A read issued last cycle and not stalled lands now; otherwise replay the held word.
  assign instr_o       = take_q ? ram_dout_i : hold_q;
  assign pc_out_o      = pc_out_q;
  assign pc_plus1_o    = pc_plus1_q;
  assign instr_valid_o = valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    pc_plus1_d    = pc_plus1_q;
    valid_d       = valid_q;
    take_d        = 1'b0;
    ld_addr_d     = ld_addr_q;
    ld_data_d     = ld_data_q;
    redirect      = 1'b0;
    redirect_addr = branch_en_i ? branch_addr_i : jump_addr_i;
    ram_re_o      = 1'b0;
    ram_we_o      = 1'b0;
    load_ack_o    = 1'b0;
    ram_addr_o    = pc_q;
    ram_din_o     = '0;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (load_req_i) begin
          ld_addr_d = load_addr_i;
          ld_data_d = load_data_i;
          state_d   = StLoad;
        end else if (run_i) begin
          state_d = StFetch;
        end
      end
      StLoad: begin
        // Gating with reset aborts a write caught by reset in this cycle.
        ram_we_o   = ~reset_i;
        load_ack_o = ~reset_i;
        ram_addr_o = ld_addr_q;
        ram_din_o  = ld_data_q;
        valid_d    = 1'b0;
        state_d    = StIdle;
      end
      StFetch: begin
        ram_re_o = 1'b1;
        take_d   = ~stall_i;
        redirect = branch_en_i | jump_en_i;
        if (redirect) begin
          pc_d = redirect_addr;
        end
        if (!run_i) begin
          // PC stays on the discarded address so a restart refetches it.
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (redirect) begin
          valid_d = 1'b0;
        end else if (!stall_i) begin
          valid_d    = 1'b1;
          pc_out_d   = pc_q;
          pc_plus1_d = pc_q + ADDR_W'(1);
          pc_d       = pc_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      pc_out_q   <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      take_q     <= 1'b0;
      hold_q     <= '0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      take_q     <= take_d;
      hold_q     <= instr_o;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, redir_cnt_q;

  assign fetch_count_o    = fetch_cnt_q;
  assign redirect_count_o = redir_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (valid_q && !stall_i && fetch_cnt_q != 16'hFFFF) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (redirect && redir_cnt_q != 16'hFFFF) begin
        redir_cnt_q <= redir_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table for the load/run/stall/redirect/wrap
// scenarios, a reset-during-load sequence, then random traffic against a cycle model.
module tb_fetch_sequencer;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MFetch = 2;

  typedef struct {
    bit            run, stall, je, be, lr;
    logic [AW-1:0] ja, ba, la;
    logic [DW-1:0] ld;
    bit            e_valid, e_ack, e_we, e_re, c_addr;
    logic [AW-1:0] e_pc, e_addr;
    logic [DW-1:0] e_instr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, run, stall, jump_en, branch_en, load_req;
  logic [AW-1:0] jump_addr, branch_addr, load_addr;
  logic [DW-1:0] load_data;
  logic          load_ack, ram_we, ram_re, instr_valid;
  logic [AW-1:0] ram_addr, pc_out, pc_plus1;
  logic [DW-1:0] ram_din, instr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] ram [16] = '{default: '0};
`ifdef FETCH_PERF_EN
  logic [15:0]   fetch_count, redirect_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_mode;
  bit            m_valid;
  logic [AW-1:0] m_pc, m_pc_out, m_pc_p1, m_la;
  logic [DW-1:0] m_ld;
  logic [DW-1:0] m_mem [16];
  int            m_fc, m_rc;

  vec_t vt[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram[ram_addr];
  end

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_i           (run),
    .stall_i         (stall),
    .jump_en_i       (jump_en),
    .jump_addr_i     (jump_addr),
    .branch_en_i     (branch_en),
    .branch_addr_i   (branch_addr),
    .load_req_i      (load_req),
    .load_addr_i     (load_addr),
    .load_data_i     (load_data),
    .load_ack_o      (load_ack),
    .ram_addr_o      (ram_addr),
    .ram_we_o        (ram_we),
    .ram_re_o        (ram_re),
    .ram_din_o       (ram_din),
    .ram_dout_i      (ram_dout),
    .instr_o         (instr),
    .pc_out_o        (pc_out),
    .pc_plus1_o      (pc_plus1),
`ifdef FETCH_PERF_EN
    .fetch_count_o   (fetch_count),
    .redirect_count_o(redirect_count),
`endif
    .instr_valid_o   (instr_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit s, bit je, int ja, bit be, int ba, bit lr, int la,
                              logic [DW-1:0] ld, bit ev, int epc, logic [DW-1:0] ein,
                              bit eack, bit ewe, bit ere, bit ca, int ea);
    vec_t v;
    v.run = r; v.stall = s; v.je = je; v.ja = AW'(ja); v.be = be; v.ba = AW'(ba);
    v.lr = lr; v.la = AW'(la); v.ld = ld;
    v.e_valid = ev; v.e_pc = AW'(epc); v.e_instr = ein;
    v.e_ack = eack; v.e_we = ewe; v.e_re = ere; v.c_addr = ca; v.e_addr = AW'(ea);
    return v;
  endfunction

  function automatic int sat16(int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_valid = 1'b0;
    m_pc = '0; m_pc_out = '0; m_pc_p1 = '0; m_la = '0; m_ld = '0;
    m_fc = 0; m_rc = 0;
  endtask

  // Advances the model by one cycle using the inputs currently driven.
  task automatic model_step();
    bit            redir;
    logic [AW-1:0] tgt;
    if (reset) begin
      model_reset();
      return;
    end
    redir = branch_en || jump_en;
    tgt   = branch_en ? branch_addr : jump_addr;
    if (m_valid && !stall) m_fc = sat16(m_fc + 1);
    case (m_mode)
      MIdle: begin
        m_valid = 1'b0;
        if (load_req) begin
          m_la = load_addr; m_ld = load_data; m_mode = MLoad;
        end else if (run) begin
          m_mode = MFetch;
        end
      end
      MLoad: begin
        m_mem[m_la] = m_ld;
        m_valid = 1'b0;
        m_mode = MIdle;
      end
      default: begin
        if (!run) begin
          m_mode = MIdle; m_valid = 1'b0;
        end
        if (redir) begin
          m_pc = tgt; m_valid = 1'b0; m_rc = sat16(m_rc + 1);
        end else if (run && !stall) begin
          m_valid  = 1'b1;
          m_pc_out = m_pc;
          m_pc_p1  = AW'((int'(m_pc) + 1) % 16);
          m_pc     = AW'((int'(m_pc) + 1) % 16);
        end
      end
    endcase
  endtask

  task automatic model_check();
    check("rnd ram_re", 32'(ram_re), 32'(m_mode == MFetch));
    check("rnd ram_we", 32'(ram_we), 32'(m_mode == MLoad && !reset));
    check("rnd load_ack", 32'(load_ack), 32'(m_mode == MLoad && !reset));
    check("rnd instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_mode == MLoad) begin
      check("rnd load addr", 32'(ram_addr), 32'(m_la));
      check("rnd load din", ram_din, m_ld);
    end
    if (m_mode == MFetch) check("rnd fetch addr", 32'(ram_addr), 32'(m_pc));
    if (m_valid) begin
      check("rnd pc_out", 32'(pc_out), 32'(m_pc_out));
      check("rnd pc_plus1", 32'(pc_plus1), 32'(m_pc_p1));
      check("rnd instr", instr, m_mem[m_pc_out]);
    end
`ifdef FETCH_PERF_EN
    check("rnd fetch_count", 32'(fetch_count), 32'(m_fc));
    check("rnd redirect_count", 32'(redirect_count), 32'(m_rc));
`endif
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit use_model);
    settle();
    if (use_model) model_check();
    advance();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ram_we"}, 32'(ram_we), 32'd0);
    check({tag, " ram_re"}, 32'(ram_re), 32'd0);
    check({tag, " load_ack"}, 32'(load_ack), 32'd0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_din"}, ram_din, 32'd0);
    check({tag, " instr"}, instr, 32'd0);
    check({tag, " pc_out"}, 32'(pc_out), 32'd0);
    check({tag, " pc_plus1"}, 32'(pc_plus1), 32'd0);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, " fetch_count"}, 32'(fetch_count), 32'd0);
    check({tag, " redirect_count"}, 32'(redirect_count), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    reset = 1'b1; run = 1'b0; stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    load_req = 1'b0; jump_addr = '0; branch_addr = '0; load_addr = '0; load_data = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    settle();
    check_reset_values("por");

    // r s je ja be ba lr la ld | valid pc instr ack we re chk_addr addr
    vt.push_back(mk(0,0,0,0,0,0,1,0,'hA0, 0,0,0,0,0,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0,1,0,'hA0, 0,0,0,1,1,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0,1,1,'hA1, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,1,'hA1, 0,0,0,1,1,0,1,1));
    vt.push_back(mk(0,0,0,0,0,0,1,2,'hA2, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,2,'hA2, 0,0,0,1,1,0,1,2));
    vt.push_back(mk(0,0,0,0,0,0,1,3,'hA3, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,1,3,'hA3, 0,0,0,1,1,0,1,3));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,1,1,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,0,'hA0,0,0,1,1,1));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,1,'hA1,0,0,1,1,2));
    vt.push_back(mk(1,1,0,0,0,0,0,0,0,    1,2,'hA2,0,0,1,1,3));
    vt.push_back(mk(1,1,0,0,0,0,0,0,0,    1,2,'hA2,0,0,1,1,3));
    vt.push_back(mk(1,1,0,0,0,0,0,0,0,    1,2,'hA2,0,0,1,1,3));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,2,'hA2,0,0,1,1,3));
    vt.push_back(mk(1,0,1,3,0,0,0,0,0,    1,3,'hA3,0,0,1,1,4));
    vt.push_back(mk(1,0,1,5,1,9,0,0,0,    0,0,0,0,0,1,1,3));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,1,1,9));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,9,0,0,0,1,1,10));
    vt.push_back(mk(1,0,1,14,0,0,0,0,0,   1,10,0,0,0,1,1,11));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,1,1,14));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,14,0,0,0,1,1,15));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,15,0,0,0,1,1,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,0,'hA0,0,0,1,1,1));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,1,'hA1,0,0,1,1,2));
    vt.push_back(mk(1,0,0,0,0,0,1,5,'h55, 1,2,'hA2,0,0,1,1,3));
    vt.push_back(mk(1,0,0,0,0,0,1,5,'h55, 1,3,'hA3,0,0,1,1,4));
    vt.push_back(mk(0,0,0,0,0,0,1,5,'h55, 1,4,0,0,0,1,1,5));
    vt.push_back(mk(0,0,0,0,0,0,1,5,'h55, 0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,    0,0,0,1,1,0,1,5));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,1,5,0,0,0,0,0,    0,0,0,0,0,1,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    0,0,0,0,0,1,1,5));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,    1,5,'h55,0,0,1,1,6));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,    1,6,0,0,0,1,1,7));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0,0));

    foreach (vt[i]) begin
      run = vt[i].run; stall = vt[i].stall;
      jump_en = vt[i].je; jump_addr = vt[i].ja;
      branch_en = vt[i].be; branch_addr = vt[i].ba;
      load_req = vt[i].lr; load_addr = vt[i].la; load_data = vt[i].ld;
      settle();
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      check($sformatf("row%0d load_ack", i), 32'(load_ack), 32'(vt[i].e_ack));
      check($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vt[i].e_we));
      check($sformatf("row%0d ram_re", i), 32'(ram_re), 32'(vt[i].e_re));
      if (vt[i].c_addr) check($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
      if (vt[i].e_valid) begin
        check($sformatf("row%0d pc_out", i), 32'(pc_out), 32'(vt[i].e_pc));
        check($sformatf("row%0d pc_plus1", i), 32'(pc_plus1), 32'(AW'(vt[i].e_pc + 4'd1)));
        check($sformatf("row%0d instr", i), instr, vt[i].e_instr);
      end
      advance();
    end

    // Reset arriving in the LOAD cycle must abort the write.
    run = 1'b0; jump_en = 1'b0; branch_en = 1'b0; stall = 1'b0;
    load_req = 1'b1; load_addr = 4'd7; load_data = 32'h77;
    tick(1'b0);
    load_req = 1'b0; reset = 1'b1;
    tick(1'b0);
    reset = 1'b0; run = 1'b1;
    settle();
    check_reset_values("ldrst");
    advance();
    jump_en = 1'b1; jump_addr = 4'd7;
    tick(1'b0);
    jump_en = 1'b0;
    settle();
    check("ldrst redirect addr", 32'(ram_addr), 32'd7);
    advance();
    settle();
    check("ldrst valid", 32'(instr_valid), 32'd1);
    check("ldrst pc_out", 32'(pc_out), 32'd7);
    check("ldrst aborted write", instr, 32'd0);
    advance();

    for (int c = 0; c < 3000; c++) begin
      run         = ($urandom_range(9, 0) != 0);
      stall       = ($urandom_range(3, 0) == 0);
      jump_en     = ($urandom_range(9, 0) == 0);
      branch_en   = ($urandom_range(11, 0) == 0);
      jump_addr   = AW'($urandom_range(15, 0));
      branch_addr = AW'($urandom_range(15, 0));
      load_req    = ($urandom_range(7, 0) == 0);
      load_addr   = AW'($urandom_range(15, 0));
      load_data   = $urandom;
      tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
